// File: rtl/multicycle_adder.sv
// multicycle_adder: ripple-carry add/sub over WIDTH bits, DIGIT bits per clock, start/busy/done handshake
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] carries,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] ra, rb, acc_s, acc_c, fs, fc;
  logic             carry, cy, last;
  logic [DIGIT-1:0] sa, sb, ss, sc;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = idx == IW'(N - 1);
  always_comb begin
    sa = ra[idx*DIGIT +: DIGIT];
    sb = rb[idx*DIGIT +: DIGIT];
    ss = '0;
    sc = '0;
    cy = carry;
    for (int i = 0; i < DIGIT; i++) begin
      ss[i] = sa[i] ^ sb[i] ^ cy;
      cy    = (sa[i] & sb[i]) | (cy & (sa[i] ^ sb[i]));
      sc[i] = cy;
    end
    fs = acc_s;
    fc = acc_c;
    fs[idx*DIGIT +: DIGIT] = ss;
    fc[idx*DIGIT +: DIGIT] = sc;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      ra       <= '0;
      rb       <= '0;
      carry    <= 1'b0;
      acc_s    <= '0;
      acc_c    <= '0;
      s        <= '0;
      carries  <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      acc_s <= fs;
      acc_c <= fc;
      carry <= cy;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        state    <= DONE;
        s        <= fs;
        carries  <= fc;
        c_out    <= fc[WIDTH-1];
        overflow <= fc[WIDTH-1] ^ fc[WIDTH-2];
      end
    end else if (start) begin
      state <= RUN;
      idx   <= '0;
      ra    <= a;
      rb    <= sub ? ~b : b;
      carry <= c_in;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed vectors for the multi-cycle adder at DIGIT=2 and DIGIT=8
module tb_multicycle_adder;
  logic       clock = 0, reset = 1;
  logic       start = 0, sub = 0, c_in = 0;
  logic [7:0] a = 0, b = 0;
  logic [7:0] s, carries;
  logic       c_out, overflow, busy, done;
  logic       start2 = 0, sub2 = 0, c_in2 = 0;
  logic [7:0] a2 = 0, b2 = 0;
  logic [7:0] s2, carries2;
  logic       c_out2, overflow2, busy2, done2;
  int         pass = 0, total = 0;

  multicycle_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clock(clock), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .s(s), .carries(carries), .c_out(c_out), .overflow(overflow), .busy(busy), .done(done)
  );
  multicycle_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clock(clock), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(c_in2),
    .s(s2), .carries(carries2), .c_out(c_out2), .overflow(overflow2), .busy(busy2), .done(done2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // mode 1 pulses a stray start mid-RUN; operands are scrambled after acceptance either way
  task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                    input logic icin, input int mode, input logic [7:0] ps, input logic [7:0] es,
                    input logic [7:0] ec, input logic eco, input logic eov);
    int cyc, nb;
    nb = 0;
    @(negedge clock);
    a = ia; b = ib; sub = isub; c_in = icin; start = 1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin start = 0; a = ~ia; b = ~ib; sub = ~isub; c_in = ~icin; end
      if (mode == 1 && cyc == 2) begin start = 1; a = 8'hAA; b = 8'h55; end
      if (mode == 1 && cyc == 3) start = 0;
      if (cyc == 3) check({tag, " hold"}, s, ps);
      if (busy) nb++;
      if (done) break;
    end
    check({tag, " latency"}, cyc, 5);
    check({tag, " busy"}, nb, 4);
    check({tag, " s"}, s, es);
    check({tag, " carries"}, carries, ec);
    check({tag, " c_out"}, c_out, eco);
    check({tag, " overflow"}, overflow, eov);
    @(negedge clock);
    check({tag, " done once"}, done, 0);
  endtask

  initial begin
    int n, nd, d0, d1, d2;
    #2;
    check("rst s", s, 0);
    check("rst carries", carries, 0);
    check("rst flags", {c_out, overflow, busy, done}, 0);
    check("rst8 flags", {s2, c_out2, overflow2, busy2, done2}, 0);
    @(negedge clock);
    reset = 0;
    op("add0F01", 8'h0F, 8'h01, 0, 0, 0, 8'h00, 8'h10, 8'h0F, 0, 0);
    op("addFF01", 8'hFF, 8'h01, 0, 0, 0, 8'h10, 8'h00, 8'hFF, 1, 0);
    op("add7F01", 8'h7F, 8'h01, 0, 0, 0, 8'h00, 8'h80, 8'h7F, 0, 1);
    op("sub0507", 8'h05, 8'h07, 1, 1, 0, 8'h80, 8'hFE, 8'h01, 0, 0);
    op("sub8001", 8'h80, 8'h01, 1, 1, 0, 8'hFE, 8'h7F, 8'h80, 1, 1);
    op("ignore", 8'h0F, 8'h01, 0, 0, 1, 8'h7F, 8'h10, 8'h0F, 0, 0);
    // asynchronous reset two cycles into RUN
    @(negedge clock);
    a = 8'h0F; b = 8'h01; sub = 0; c_in = 0; start = 1;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    #2 reset = 1;
    #1;
    check("arst s", s, 0);
    check("arst carries", carries, 0);
    check("arst flags", {c_out, overflow, busy, done}, 0);
    @(negedge clock);
    reset = 0;
    nd = 0;
    repeat (6) begin @(negedge clock); if (done || busy) nd++; end
    check("arst no done", nd, 0);
    op("post rst", 8'hFF, 8'h01, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0);
    // start held high: back-to-back operations
    @(negedge clock);
    a = 8'h0F; b = 8'h01; sub = 0; c_in = 0; start = 1;
    nd = 0; d0 = 0; d1 = 0; d2 = 0;
    for (n = 1; n <= 16; n++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        if (nd == 1) d0 = n;
        if (nd == 2) d1 = n;
        if (nd == 3) d2 = n;
        check("b2b s", s, 8'h10);
      end
    end
    start = 0;
    check("b2b count", nd, 3);
    check("b2b first", d0, 5);
    check("b2b gap1", d1 - d0, 5);
    check("b2b gap2", d2 - d1, 5);
    repeat (6) @(negedge clock);
    check("b2b idle", {busy, done}, 0);
    // DIGIT == WIDTH
    @(negedge clock);
    a2 = 8'h0F; b2 = 8'h01; sub2 = 0; c_in2 = 0; start2 = 1;
    @(negedge clock);
    start2 = 0; a2 = 8'hAA;
    check("d8 busy", {busy2, done2}, 2'b10);
    @(negedge clock);
    check("d8 done", {busy2, done2}, 2'b01);
    check("d8 s", s2, 8'h10);
    check("d8 carries", carries2, 8'h0F);
    check("d8 flags", {c_out2, overflow2}, 0);
    @(negedge clock);
    check("d8 done once", done2, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
